// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD SPI command path: sequencer state encoding,
// fill and CRC byte constants, and the CRC lookup used when framing commands.
package sd_spi_pkg;

  typedef enum logic [2:0] {
    StPwrup,
    StIdle,
    StCmd,
    StPoll,
    StTrail
  } state_e;

  localparam logic [7:0]  FILL_BYTE       = 8'hFF;
  localparam logic [7:0]  CRC_CMD0        = 8'h95;
  localparam logic [7:0]  CRC_CMD8        = 8'h87;
  localparam logic [7:0]  CRC_DEFAULT     = 8'h01;
  localparam int unsigned CMD_FRAME_BYTES = 6;

  // Only CMD0 and CMD8 are CRC-checked by a card in SPI mode; every other
  // command gets a dummy CRC with the end bit set.
  function automatic logic [7:0] crc_byte(input logic [5:0] index);
    logic [7:0] crc;
    case (index)
      6'd0:    crc = CRC_CMD0;
      6'd8:    crc = CRC_CMD8;
      default: crc = CRC_DEFAULT;
    endcase
    return crc;
  endfunction

endpackage

// File: rtl/sd_spi_cmd_sequencer_if.sv
// Command/response bus between a requester and the SD SPI command sequencer.
//   cmd_valid/cmd_ready : command handshake, cmd_index/cmd_arg sampled at accept
//   resp_valid          : one-cycle pulse, resp_r1/resp_timeout held until next pulse
// Modports: master = requester, slave = sequencer.
interface sd_spi_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_valid;
  logic [7:0]  resp_r1;
  logic        resp_timeout;

  modport master (
    output cmd_valid,
    output cmd_index,
    output cmd_arg,
    input  cmd_ready,
    input  resp_valid,
    input  resp_r1,
    input  resp_timeout
  );

  modport slave (
    input  cmd_valid,
    input  cmd_index,
    input  cmd_arg,
    output cmd_ready,
    output resp_valid,
    output resp_r1,
    output resp_timeout
  );
endinterface

// File: rtl/sd_cmd_framer.sv
// Combinational selector for byte k (0..5) of an SD command frame.
//   byte_sel_i   : frame byte number
//   cmd_index_i  : SD command number
//   cmd_arg_i    : 32-bit argument, MSB byte first on the wire
//   frame_byte_o : selected byte ({01,index}, arg bytes, CRC)
module sd_cmd_framer
  import sd_spi_pkg::*;
(
  input  logic [2:0]  byte_sel_i,
  input  logic [5:0]  cmd_index_i,
  input  logic [31:0] cmd_arg_i,
  output logic [7:0]  frame_byte_o
);

  always_comb begin
    frame_byte_o = FILL_BYTE;
    case (byte_sel_i)
      3'd0:    frame_byte_o = {2'b01, cmd_index_i};
      3'd1:    frame_byte_o = cmd_arg_i[31:24];
      3'd2:    frame_byte_o = cmd_arg_i[23:16];
      3'd3:    frame_byte_o = cmd_arg_i[15:8];
      3'd4:    frame_byte_o = cmd_arg_i[7:0];
      3'd5:    frame_byte_o = crc_byte(cmd_index_i);
      default: frame_byte_o = FILL_BYTE;
    endcase
  end

endmodule

// File: rtl/sd_spi_cmd_sequencer.sv
// SD card command sequencer above a byte-level SPI transceiver. Runs power-up
// clocking, then frames one command at a time, polls for R1 and returns it.
//   clk, reset   : clock, asynchronous active-high reset
//   cmd_bus      : command/response bus (slave side)
//   powerup_done : sticky once power-up clocking has finished
//   cs_n         : SD chip select, active low, only changes while byte_req=0
//   byte_req/byte_tx/byte_ack/byte_rx : one-byte request/acknowledge exchange
module sd_spi_cmd_sequencer
  import sd_spi_pkg::*;
#(
  parameter int unsigned INIT_BYTES   = 10,
  parameter int unsigned RESP_TIMEOUT = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  sd_spi_cmd_sequencer_if.slave  cmd_bus,
  output logic                   powerup_done,
  output logic                   cs_n,
  output logic                   byte_req,
  output logic [7:0]             byte_tx,
  input  logic                   byte_ack,
  input  logic [7:0]             byte_rx
);

  localparam logic [CNT_W-1:0] InitLast    = CNT_W'(INIT_BYTES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FrameLast   = CNT_W'(CMD_FRAME_BYTES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [5:0]        index_q, index_d;
  logic [31:0]       arg_q, arg_d;
  logic [7:0]        r1_q, r1_d;
  logic              timeout_q, timeout_d;
  logic              resp_valid_q, resp_valid_d;
  logic              powerup_done_q, powerup_done_d;
  logic              cs_n_q, cs_n_d;
  logic              ack;
  logic [7:0]        frame_byte;

  // Acks arriving while no byte is requested are dropped here.
  assign ack = req_q & byte_ack;

  sd_cmd_framer u_framer (
    .byte_sel_i   (cnt_q[2:0]),
    .cmd_index_i  (index_q),
    .cmd_arg_i    (arg_q),
    .frame_byte_o (frame_byte)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StPwrup;
      cnt_q          <= '0;
      req_q          <= 1'b0;
      index_q        <= '0;
      arg_q          <= '0;
      r1_q           <= FILL_BYTE;
      timeout_q      <= 1'b0;
      resp_valid_q   <= 1'b0;
      powerup_done_q <= 1'b0;
      cs_n_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      index_q        <= index_d;
      arg_q          <= arg_d;
      r1_q           <= r1_d;
      timeout_q      <= timeout_d;
      resp_valid_q   <= resp_valid_d;
      powerup_done_q <= powerup_done_d;
      cs_n_q         <= cs_n_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    arg_d          = arg_q;
    r1_d           = r1_q;
    timeout_d      = timeout_q;
    resp_valid_d   = 1'b0;
    powerup_done_d = powerup_done_q;

    case (state_q)
      StPwrup: begin
        if (ack && cnt_q == InitLast) begin
          state_d        = StIdle;
          powerup_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (cmd_bus.cmd_valid) begin
          state_d = StCmd;
          index_d = cmd_bus.cmd_index;
          arg_d   = cmd_bus.cmd_arg;
        end
      end
      StCmd: begin
        if (ack && cnt_q == FrameLast) state_d = StPoll;
      end
      StPoll: begin
        if (ack) begin
          if (!byte_rx[7]) begin
            state_d   = StTrail;
            r1_d      = byte_rx;
            timeout_d = 1'b0;
          end else if (cnt_q == TimeoutLast) begin
            state_d   = StTrail;
            r1_d      = FILL_BYTE;
            timeout_d = 1'b1;
          end
        end
      end
      StTrail: begin
        if (ack) begin
          state_d      = StIdle;
          resp_valid_d = 1'b1;
        end
      end
      default: state_d = StPwrup;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (ack) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    // A new request starts only in a cycle that neither acks nor changes
    // state, so req drops for at least one cycle between bytes and cs_n
    // settles before the first byte of a state goes out.
    if (ack) begin
      req_d = 1'b0;
    end else begin
      req_d = req_q | ((state_q != StIdle) && (state_d == state_q));
    end

    cs_n_d = !((state_d == StCmd) || (state_d == StPoll) || (state_d == StTrail));
  end

  // Outputs
  always_comb begin
    cmd_bus.cmd_ready = (state_q == StIdle);
    byte_tx           = (state_q == StCmd) ? frame_byte : FILL_BYTE;
  end

  assign cmd_bus.resp_valid   = resp_valid_q;
  assign cmd_bus.resp_r1      = r1_q;
  assign cmd_bus.resp_timeout = timeout_q;
  assign powerup_done         = powerup_done_q;
  assign cs_n                 = cs_n_q;
  assign byte_req             = req_q;

endmodule

// File: tb/tb_sd_spi_cmd_sequencer.sv
module tb_sd_spi_cmd_sequencer;

  localparam int INIT_BYTES   = 10;
  localparam int RESP_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       powerup_done, cs_n, byte_req, byte_ack;
  logic [7:0] byte_tx, byte_rx;
  logic       ack_resp, ack_spur;

  int n_vec = 0;
  int n_fail = 0;
  int proto_err = 0;

  logic [7:0] rx_q[$];
  logic [8:0] tx_log[$];  // {cs_n, byte} per exchanged byte

  always #5 clk = ~clk;

  assign byte_ack = ack_resp | ack_spur;

  sd_spi_cmd_sequencer_if cmd_bus ();

  sd_spi_cmd_sequencer #(
    .INIT_BYTES   (INIT_BYTES),
    .RESP_TIMEOUT (RESP_TIMEOUT),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_bus      (cmd_bus),
    .powerup_done (powerup_done),
    .cs_n         (cs_n),
    .byte_req     (byte_req),
    .byte_tx      (byte_tx),
    .byte_ack     (byte_ack),
    .byte_rx      (byte_rx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transceiver model: acks on the third cycle of a request, logs what was
  // sent and checks that byte_tx/cs_n hold still while the request is up.
  initial begin
    int         pend;
    logic [7:0] tx_hold;
    logic       cs_hold;
    pend     = 0;
    ack_resp = 1'b0;
    byte_rx  = 8'hFF;
    tx_hold  = 8'h00;
    cs_hold  = 1'b1;
    forever begin
      @(negedge clk);
      if (reset) begin
        ack_resp = 1'b0;
        pend     = 0;
      end else if (ack_resp) begin
        ack_resp = 1'b0;
        pend     = 0;
        if (byte_req) proto_err++;
      end else if (byte_req) begin
        if (pend == 0) begin
          tx_hold = byte_tx;
          cs_hold = cs_n;
        end else if (byte_tx !== tx_hold || cs_n !== cs_hold) begin
          proto_err++;
        end
        pend++;
        if (pend == 3) begin
          ack_resp = 1'b1;
          byte_rx  = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hFF;
          tx_log.push_back({cs_n, byte_tx});
        end
      end else begin
        pend = 0;
      end
    end
  end

  task automatic wait_powerup(input string tag);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      if (powerup_done) got = 1'b1;
    end
    chk({tag, "_done"}, got, 1'b1);
    chk({tag, "_ready"}, cmd_bus.cmd_ready, 1'b1);
    chk({tag, "_nbytes"}, tx_log.size(), INIT_BYTES);
    for (int i = 0; i < tx_log.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), tx_log[i], {1'b1, 8'hFF});
  endtask

  // n_ff: poll bytes answered 0xFF before r1; n_ff >= RESP_TIMEOUT never answers.
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input int n_ff, input logic [7:0] r1, input bit hold_valid);
    logic [7:0] exp_q[$];
    logic [7:0] exp_r1;
    logic       exp_to;
    int         polls;
    bit         got;

    exp_q = {};
    exp_q.push_back({2'b01, idx});
    exp_q.push_back(arg[31:24]);
    exp_q.push_back(arg[23:16]);
    exp_q.push_back(arg[15:8]);
    exp_q.push_back(arg[7:0]);
    exp_q.push_back(idx == 6'd0 ? 8'h95 : (idx == 6'd8 ? 8'h87 : 8'h01));
    if (n_ff < RESP_TIMEOUT) begin
      polls  = n_ff + 1;
      exp_r1 = r1;
      exp_to = 1'b0;
    end else begin
      polls  = RESP_TIMEOUT;
      exp_r1 = 8'hFF;
      exp_to = 1'b1;
    end
    repeat (polls + 1) exp_q.push_back(8'hFF);

    // Bytes received during the frame look like responses and must be ignored.
    rx_q = {};
    repeat (6) rx_q.push_back(8'($urandom_range(0, 127)));
    repeat (n_ff) rx_q.push_back(8'h80 | 8'($urandom_range(0, 127)));
    rx_q.push_back(r1);
    rx_q.push_back(8'($urandom_range(0, 255)));
    tx_log = {};

    @(negedge clk);
    chk({tag, "_ready"}, cmd_bus.cmd_ready, 1'b1);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_index = idx;
    cmd_bus.cmd_arg   = arg;
    @(negedge clk);
    chk({tag, "_busy"}, cmd_bus.cmd_ready, 1'b0);
    if (hold_valid) begin
      cmd_bus.cmd_index = ~idx;
      cmd_bus.cmd_arg   = ~arg;
    end else begin
      cmd_bus.cmd_valid = 1'b0;
    end

    got = 1'b0;
    for (int c = 0; c < 2000 && !got; c++) begin
      if (cmd_bus.resp_valid) got = 1'b1;
      else @(negedge clk);
    end
    cmd_bus.cmd_valid = 1'b0;
    chk({tag, "_resp_seen"}, got, 1'b1);
    chk({tag, "_r1"}, cmd_bus.resp_r1, exp_r1);
    chk({tag, "_timeout"}, cmd_bus.resp_timeout, exp_to);
    chk({tag, "_csn_end"}, cs_n, 1'b1);
    chk({tag, "_ready_end"}, cmd_bus.cmd_ready, 1'b1);
    chk({tag, "_nbytes"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), tx_log[i], {1'b0, exp_q[i]});
    @(negedge clk);
    chk({tag, "_pulse"}, cmd_bus.resp_valid, 1'b0);
    chk({tag, "_r1_held"}, cmd_bus.resp_r1, exp_r1);
  endtask

  initial begin
    logic [31:0] rarg;
    bit          hit;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_index = '0;
    cmd_bus.cmd_arg   = '0;
    ack_spur          = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_bus.cmd_ready, 1'b0);
    chk("rst_rvalid", cmd_bus.resp_valid, 1'b0);
    chk("rst_r1", cmd_bus.resp_r1, 8'hFF);
    chk("rst_to", cmd_bus.resp_timeout, 1'b0);
    chk("rst_pwr", powerup_done, 1'b0);
    chk("rst_csn", cs_n, 1'b1);
    chk("rst_req", byte_req, 1'b0);
    chk("rst_tx", byte_tx, 8'hFF);
    tx_log = {};
    reset  = 1'b0;
    wait_powerup("pwrup");

    run_cmd("cmd0", 6'd0, 32'h0, 1, 8'h01, 1'b0);
    run_cmd("cmd8", 6'd8, 32'h0000_01AA, 0, 8'h05, 1'b0);
    run_cmd("cmd17", 6'd17, $urandom, RESP_TIMEOUT, 8'h00, 1'b0);
    run_cmd("hold", 6'd55, $urandom, 2, 8'h00, 1'b1);

    // Spurious ack while idle
    @(negedge clk);
    tx_log   = {};
    ack_spur = 1'b1;
    @(negedge clk);
    ack_spur = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_ready", cmd_bus.cmd_ready, 1'b1);
    chk("spur_req", byte_req, 1'b0);
    chk("spur_csn", cs_n, 1'b1);
    chk("spur_nbytes", tx_log.size(), 0);

    for (int k = 0; k < 6; k++)
      run_cmd($sformatf("rnd%0d", k), 6'($urandom_range(0, 63)), $urandom,
              $urandom_range(0, RESP_TIMEOUT + 1), 8'($urandom_range(0, 127)), 1'b0);

    // Reset while the third frame byte is being requested
    rarg   = $urandom;
    rx_q   = {};
    tx_log = {};
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_index = 6'd17;
    cmd_bus.cmd_arg   = rarg;
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(posedge clk);
      #2;
      if (byte_req && tx_log.size() == 2) hit = 1'b1;
    end
    chk("mid_reached", hit, 1'b1);
    chk("mid_b1", tx_log.size() > 1 ? tx_log[1] : 9'h1FF, {1'b0, rarg[31:24]});
    reset = 1'b1;
    #1;
    chk("mid_csn", cs_n, 1'b1);
    chk("mid_req", byte_req, 1'b0);
    chk("mid_pwr", powerup_done, 1'b0);
    @(negedge clk);
    tx_log = {};
    rx_q   = {};
    reset  = 1'b0;
    wait_powerup("repwr");

    chk("protocol", proto_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_spi_cmd_sequencer.md
Name: sd_spi_cmd_sequencer

Overview:
Command-level controller sitting above the byte-level SPI transceiver in the SD card path. It runs the SD power-up clocking (0xFF bytes with chip select released), then accepts one SD command at a time (index + 32-bit argument). For each command it emits the 6-byte frame, polls with 0xFF until an R1 response arrives or the poll limit expires, and returns the R1 byte to the requester. It owns chip select and drives the transceiver through a one-byte request/acknowledge handshake.

Parameters:
INIT_BYTES, 10, number of 0xFF bytes sent with cs_n=1 after reset (80 SCK cycles)
RESP_TIMEOUT, 8, maximum poll bytes after the frame before the response is declared timed out
CNT_W, 4, width of the byte counter; must hold max(INIT_BYTES, RESP_TIMEOUT)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  sequencer idle, command accepted when cmd_valid&cmd_ready
cmd_index  input  6  SD command number
cmd_arg  input  32  command argument, MSB sent first
resp_valid  output  1  one-cycle pulse, response available
resp_r1  output  8  R1 byte, held until next resp_valid
resp_timeout  output  1  qualifies resp_valid: no response within RESP_TIMEOUT, held with resp_r1
powerup_done  output  1  power-up clocking finished; sticky until reset
cs_n  output  1  SD chip select, active low
byte_req  output  1  request transceiver to exchange byte_tx
byte_tx  output  8  byte to shift out, stable while byte_req=1
byte_ack  input  1  one-cycle pulse: byte exchanged, byte_rx valid this cycle
byte_rx  input  8  byte shifted in

Behaviour:
- Reset values: cmd_ready=0, resp_valid=0, resp_r1=8'hFF, resp_timeout=0, powerup_done=0, cs_n=1, byte_req=0, byte_tx=8'hFF. FSM enters PWRUP the first cycle after reset deasserts.
- Byte handshake: byte_req rises with byte_tx already valid, then holds until the byte_ack cycle. byte_req is low the cycle after ack, and is low for at least one cycle between bytes. byte_ack while byte_req=0 is ignored.
- States:
  - PWRUP: cs_n=1. Sends INIT_BYTES of 0xFF. After the last ack: powerup_done=1, go to IDLE.
  - IDLE: cmd_ready=1, cs_n=1. On accept, latch index/arg, cmd_ready=0, go to CMD.
  - CMD: cs_n=0 from the cycle after accept. Sends 6 bytes:
    - {2'b01, index}, then arg[31:24], arg[23:16], arg[15:8], arg[7:0];
    - CRC byte: 8'h95 if index==0, 8'h87 if index==8, else 8'h01.
    - byte_rx during CMD is ignored.
  - POLL: sends 0xFF repeatedly.
    - First ack with byte_rx[7]==0: resp_r1=byte_rx, resp_timeout=0, go to TRAIL.
    - After RESP_TIMEOUT acks all with bit7=1: resp_r1=8'hFF, resp_timeout=1, go to TRAIL.
  - TRAIL: one 0xFF byte with cs_n=0. On its ack: cs_n=1, resp_valid pulses for exactly one cycle, go to IDLE (cmd_ready=1 the following cycle).
- Latency for an immediate response (poll byte 1): 8 byte exchanges from accept to resp_valid.
- Counter: CNT_W bits, cleared on every state entry, compared for equality only (no wrap in normal use).
- cmd_valid outside IDLE is ignored; cmd_* are sampled only at accept.
- Reset mid-operation: byte_req drops and cs_n goes to 1 immediately (async). The partial command is lost, powerup_done clears, and power-up reruns.
- cs_n only changes while byte_req=0.

Decomposition:
- Shared package (sd_spi_pkg): state encodings (PWRUP, IDLE, CMD, POLL, TRAIL), FILL_BYTE=8'hFF, CRC_CMD0=8'h95, CRC_CMD8=8'h87, CRC_DEFAULT=8'h01, CMD_FRAME_BYTES=6.
- One sub-module, sd_cmd_framer: combinational selection of frame byte k (0..5) from index/arg, including the CRC lookup.
- Counter and FSM stay in the top.

Test Plan:
- Reset release, transceiver acks each byte after 3 cycles: exactly 10 bytes of 0xFF with cs_n=1, then powerup_done=1 and cmd_ready=1.
- CMD0 (index 0, arg 0), byte_rx=0xFF then 0x01: bytes sent 40 00 00 00 00 95 FF FF FF. Then resp_valid pulse with resp_r1=0x01, resp_timeout=0, cs_n=1 after the trailing byte.
- CMD8 (index 8, arg 32'h000001AA), R1 on first poll = 0x05: bytes 48 00 00 01 AA 87 FF FF; resp_r1=0x05.
- CMD17 (index 17) with byte_rx always 0xFF: frame ends with CRC 0x01, exactly 8 poll bytes plus 1 trail byte. Then resp_timeout=1, resp_r1=0xFF.
- cmd_valid held high during POLL with a different index: ignored, no second frame until cmd_ready returns. Spurious byte_ack with byte_req=0: no state change.
- Reset asserted during CMD byte 3: cs_n=1 and byte_req=0 in the same cycle, powerup_done=0. After release, 10 bytes of 0xFF are sent again.
